hex_display_arbiter: RTL and testbench



---
 rtl/hex_display_arbiter_if.sv | 39 +++
 rtl/hex_display_arbiter.sv | 143 ++++++++++++++
 tb/tb_hex_display_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_arbiter_if.sv
// Bundle between the requesting clients and the hex display PIO.
// The arbiter takes the slave modport; the client/PIO side uses master.
interface hex_display_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*24-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic                  done;
  logic                  busy;
  logic [1:0]            pio_address;
  logic                  pio_chipselect;
  logic                  pio_write_n;
  logic [31:0]           pio_writedata;

  modport master (
    output req,
    output req_data,
    input  grant,
    input  done,
    input  busy,
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata
  );

  modport slave (
    input  req,
    input  req_data,
    output grant,
    output done,
    output busy,
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the six-digit hex display PIO: one write per grant,
// then the display is held for HOLD_CYCLES so the value stays readable.
module hex_display_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hex_display_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < 1 ||
      (CNT_W < 32 && 64'(HOLD_CYCLES) >= (64'(1) << CNT_W))) begin : g_bad_param
    $error("hex_display_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_valid;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cs_q, cs_d;
  logic               write_n_q, write_n_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [23:0]        req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign req_word[i] = bus.req_data[24*i +: 24];
  end

  // Rotating priority search: walking downward leaves the candidate closest to ptr.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (bus.req[(32'(ptr_q) + i - 1) % NUM_REQ]) begin
        sel_valid = 1'b1;
        sel_idx   = PTR_W'((32'(ptr_q) + i - 1) % NUM_REQ);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d = StWrite;
          gidx_d  = sel_idx;
        end
      end
      StWrite: begin
        state_d = StHold;
        cnt_d   = '0;
        ptr_d   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
      end
      StHold: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    grant_d = '0;
    if (state_d != StIdle) begin
      grant_d[gidx_d] = 1'b1;
    end
    busy_d    = (state_d != StIdle);
    cs_d      = (state_d == StWrite);
    write_n_d = (state_d != StWrite);
    done_d    = (state_d == StHold) && (cnt_d == HOLD_LAST);
    wdata_d   = wdata_q;
    if (state_q == StIdle && sel_valid) begin
      wdata_d = {8'h00, req_word[sel_idx]};
    end
  end

  // Async reset also kills an in-flight write strobe immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      wdata_q   <= '0;
    end else begin
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cs_q      <= cs_d;
      write_n_q <= write_n_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.done           = done_q;
  assign bus.busy           = busy_q;
  assign bus.pio_address    = 2'd0;
  assign bus.pio_chipselect = cs_q;
  assign bus.pio_write_n    = write_n_q;
  assign bus.pio_writedata  = wdata_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with NUM_REQ=3, HOLD_CYCLES=4.
module tb_hex_display_arbiter;

  localparam int unsigned NumReq     = 3;
  localparam int unsigned HoldCycles = 4;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  int unsigned wr_count  = 0;
  int unsigned base;

  always #5 clk = ~clk;

  hex_display_arbiter_if #(.NUM_REQ(NumReq)) bus ();

  hex_display_arbiter #(
    .NUM_REQ    (NumReq),
    .HOLD_CYCLES(HoldCycles),
    .CNT_W      (32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always @(posedge clk) begin
    if (reset_n && bus.pio_chipselect && !bus.pio_write_n) wr_count <= wr_count + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [23:0] d0, input logic [23:0] d1, input logic [23:0] d2);
    bus.req_data = {d2, d1, d0};
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    tick(3);
    reset_n = 1'b1;
  endtask

  task automatic check_write(input string tag, input logic [2:0] g, input logic [31:0] wd);
    check({tag, "_cs"},    32'(bus.pio_chipselect), 32'd1);
    check({tag, "_wn"},    32'(bus.pio_write_n),    32'd0);
    check({tag, "_grant"}, 32'(bus.grant),          32'(g));
    check({tag, "_wdata"}, bus.pio_writedata,       wd);
    check({tag, "_addr"},  32'(bus.pio_address),    32'd0);
  endtask

  task automatic check_hold(input string tag, input logic [2:0] g, input logic d);
    check({tag, "_cs"},    32'(bus.pio_chipselect), 32'd0);
    check({tag, "_wn"},    32'(bus.pio_write_n),    32'd1);
    check({tag, "_grant"}, 32'(bus.grant),          32'(g));
    check({tag, "_done"},  32'(bus.done),           32'(d));
    check({tag, "_busy"},  32'(bus.busy),           32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
  endtask

  initial begin
    logic [2:0]  rr_grant [4];
    logic [31:0] rr_data  [4];
    rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_data  = '{32'h0000_0000, 32'h0011_1111, 32'h0022_2222, 32'h0000_0000};

    // Reset values and quiet bus
    do_reset();
    check("rst_grant", 32'(bus.grant),          32'd0);
    check("rst_busy",  32'(bus.busy),           32'd0);
    check("rst_done",  32'(bus.done),           32'd0);
    check("rst_cs",    32'(bus.pio_chipselect), 32'd0);
    check("rst_wn",    32'(bus.pio_write_n),    32'd1);
    check("rst_wdata", bus.pio_writedata,       32'd0);
    check("rst_addr",  32'(bus.pio_address),    32'd0);
    tick(20);
    check("rst_no_strobe", wr_count, 32'd0);

    // Single request from requester 1
    set_data(24'h000000, 24'hABCDEF, 24'h000000);
    bus.req = 3'b010;
    base = wr_count;
    tick(1);
    check_write("single_wr", 3'b010, 32'h00AB_CDEF);
    bus.req = 3'b000;
    for (int k = 2; k <= 5; k++) begin
      tick(1);
      check_hold("single_hold", 3'b010, k == 5);
    end
    tick(1);
    check_idle("single_end");
    check("single_wr_count", wr_count - base, 32'd1);
    check("single_wdata_kept", bus.pio_writedata, 32'h00AB_CDEF);

    // Round-robin with all requesters continuously active
    do_reset();
    set_data(24'h000000, 24'h111111, 24'h222222);
    bus.req = 3'b111;
    for (int w = 0; w < 4; w++) begin
      tick(1);
      check_write("rr_wr", rr_grant[w], rr_data[w]);
      for (int j = 0; j < 4; j++) begin
        tick(1);
        check_hold("rr_hold", rr_grant[w], j == 3);
      end
      tick(1);
      check_idle("rr_idle");
    end
    bus.req = 3'b000;
    tick(2);

    // Pointer wrap: after requester 2, req=101 yields 0 then 2
    do_reset();
    set_data(24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C);
    bus.req = 3'b100;
    tick(1);
    check_write("wrap_wr2", 3'b100, 32'h000C_0C0C);
    bus.req = 3'b101;
    tick(6);
    check_write("wrap_wr0", 3'b001, 32'h000A_0A0A);
    tick(6);
    check_write("wrap_wr2b", 3'b100, 32'h000C_0C0C);
    bus.req = 3'b000;
    tick(6);
    check_idle("wrap_end");

    // No preemption; req_data sampled only at grant
    do_reset();
    set_data(24'h123456, 24'h654321, 24'h000000);
    bus.req = 3'b001;
    tick(1);
    check_write("nopre_wr0", 3'b001, 32'h0012_3456);
    tick(1);
    base = wr_count;
    bus.req = 3'b011;
    set_data(24'h999999, 24'h654321, 24'h000000);
    check_hold("nopre_hold", 3'b001, 1'b0);
    for (int k = 3; k <= 5; k++) begin
      tick(1);
      check_hold("nopre_hold", 3'b001, k == 5);
      check("nopre_wdata", bus.pio_writedata, 32'h0012_3456);
    end
    tick(1);
    check_idle("nopre_idle");
    check("nopre_no_extra_wr", wr_count - base, 32'd0);
    tick(1);
    check_write("nopre_wr1", 3'b010, 32'h0065_4321);
    tick(6);
    check_write("nopre_wr0b", 3'b001, 32'h0099_9999);
    bus.req = 3'b000;
    tick(6);

    // Reset during WRITE with a non-zero pointer
    do_reset();
    set_data(24'h111111, 24'h222222, 24'h333333);
    bus.req = 3'b010;
    tick(1);
    check_write("mrst_pre", 3'b010, 32'h0022_2222);
    bus.req = 3'b000;
    tick(5);
    check_idle("mrst_pre_idle");
    bus.req = 3'b001;
    tick(1);
    check_write("mrst_wr", 3'b001, 32'h0011_1111);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_wn",    32'(bus.pio_write_n),    32'd1);
    check("mrst_cs",    32'(bus.pio_chipselect), 32'd0);
    check("mrst_grant", 32'(bus.grant),          32'd0);
    check("mrst_busy",  32'(bus.busy),           32'd0);
    check("mrst_wdata", bus.pio_writedata,       32'd0);
    tick(2);
    reset_n = 1'b1;
    bus.req = 3'b111;
    tick(1);
    check_write("mrst_restart", 3'b001, 32'h0011_1111);
    bus.req = 3'b000;
    tick(6);
    check_idle("mrst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
